// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM command scheduler.
// Opcode and FSM state encodings plus default geometry.
package cam_ctrl_pkg;

  localparam int DW_DEF    = 4;
  localparam int AW_DEF    = 3;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOOKUP  = 2'b00,
    OP_REPLACE = 2'b01,
    OP_CLEAR   = 2'b10
  } op_t;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    LOOK,
    WR,
    RESP
  } state_t;

  // Raw opcode 11 is an alias of LOOKUP.
  function automatic op_t decode_op(input logic [1:0] raw);
    unique case (raw)
      2'b01:   decode_op = OP_REPLACE;
      2'b10:   decode_op = OP_CLEAR;
      default: decode_op = OP_LOOKUP;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Pointer remembers the last winner; reset favours requester 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       init,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       last
);

  logic r_last;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_last <= 1'b1;
    end else if (take && (gnt != 2'b00)) begin
      r_last <= gnt[1];
    end
  end

  assign last = r_last;

endmodule

// File: rtl/cam_cmd_sched.sv
// Two-requester LOOKUP/REPLACE/CLEAR scheduler driving a CAM_File.
// One command in flight; response carries hit and min/max address.
module cam_cmd_sched
  import cam_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                init,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][1:0]     req_op,
  input  logic [1:0][DW-1:0]  req_key,
  input  logic [1:0][DW-1:0]  req_new,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic                rsp_hit,
  output logic [AW-1:0]       rsp_min,
  output logic [AW-1:0]       rsp_max,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic                busy,
  output logic                cam_init,
  output logic [DW-1:0]       cam_lookup,
  output logic                cam_setD,
  output logic [DW-1:0]       cam_newD,
  input  logic                cam_valid,
  input  logic [AW-1:0]       cam_min,
  input  logic [AW-1:0]       cam_max
);

  state_t           r_state;
  state_t           w_next;
  op_t              r_op;
  op_t              w_op_sel;
  logic [DW-1:0]    r_key;
  logic [DW-1:0]    r_new;
  logic             r_hit;
  logic [AW-1:0]    r_min;
  logic [AW-1:0]    r_max;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_gnt;
  logic             w_last;
  logic             w_take;
  logic             w_acc;
  logic             w_resp;

  rr_arb2 u_arb (
    .clk  (clk),
    .init (init),
    .req  (req_valid),
    .take (w_take),
    .gnt  (w_gnt),
    .last (w_last)
  );

  assign w_take   = (r_state == IDLE);
  assign w_acc    = w_take && (w_gnt != 2'b00);
  assign w_op_sel = decode_op(req_op[w_gnt[1]]);
  assign w_resp   = (r_state == RESP);

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_state <= CLR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      CLR:  w_next = (r_op == OP_CLEAR) ? RESP : IDLE;
      IDLE: if (w_acc) w_next = (w_op_sel == OP_CLEAR) ? CLR : LOOK;
      LOOK: w_next = (r_op == OP_REPLACE && cam_valid) ? WR : RESP;
      WR:   w_next = RESP;
      RESP: w_next = IDLE;
      default: w_next = CLR;
    endcase
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_op  <= OP_LOOKUP;
      r_key <= '0;
      r_new <= '0;
      r_hit <= 1'b0;
      r_min <= '0;
      r_max <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc) begin
        r_op <= w_op_sel;
        if (w_op_sel != OP_CLEAR) r_key <= req_key[w_gnt[1]];
        if (w_op_sel == OP_REPLACE) r_new <= req_new[w_gnt[1]];
      end
      // Miss addresses are forced to zero regardless of CAM output.
      if (r_state == LOOK) begin
        r_hit <= cam_valid;
        r_min <= cam_valid ? cam_min : '0;
        r_max <= cam_valid ? cam_max : '0;
      end
      if (r_state == CLR) begin
        r_hit <= 1'b0;
        r_min <= '0;
        r_max <= '0;
      end
      if (w_resp && r_hit && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign req_ready  = w_take ? w_gnt : 2'b00;
  assign busy       = (r_state != IDLE);
  assign cam_init   = (r_state == CLR);
  assign cam_setD   = (r_state == WR);
  assign cam_lookup = r_key;
  assign cam_newD   = r_new;
  assign rsp_valid  = w_resp;
  // Pointer holds the in-flight requester: no grant happens outside IDLE.
  assign rsp_id     = w_resp & w_last;
  assign rsp_hit    = w_resp & r_hit;
  assign rsp_min    = w_resp ? r_min : '0;
  assign rsp_max    = w_resp ? r_max : '0;
  assign hit_cnt    = r_cnt;

endmodule

// File: tb/tb_cam_cmd_sched.sv
// Randomized self-checking bench for cam_cmd_sched.
// Includes a behavioural CAM_File stand-in and a command-level model.
module tb_cam_cmd_sched;

  localparam logic [3:0] TBL [8] = '{4'h0, 4'h1, 4'hB, 4'h3,
                                     4'h4, 4'hB, 4'h7, 4'h8};

  logic            clk = 1'b0;
  logic            init;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][1:0] req_op;
  logic [1:0][3:0] req_key;
  logic [1:0][3:0] req_new;
  logic            rsp_valid, rsp_id, rsp_hit;
  logic [2:0]      rsp_min, rsp_max;
  logic [7:0]      hit_cnt;
  logic            busy, cam_init, cam_setD;
  logic [3:0]      cam_lookup, cam_newD;
  logic            cam_valid;
  logic [2:0]      cam_min, cam_max;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] cam_mem [8];
  logic [3:0] ref_mem [8];
  int         ref_cnt;
  int         ref_last;

  always #5 clk = ~clk;

  cam_cmd_sched dut (
    .clk        (clk),
    .init       (init),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_key    (req_key),
    .req_new    (req_new),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_hit    (rsp_hit),
    .rsp_min    (rsp_min),
    .rsp_max    (rsp_max),
    .hit_cnt    (hit_cnt),
    .busy       (busy),
    .cam_init   (cam_init),
    .cam_lookup (cam_lookup),
    .cam_setD   (cam_setD),
    .cam_newD   (cam_newD),
    .cam_valid  (cam_valid),
    .cam_min    (cam_min),
    .cam_max    (cam_max)
  );

  // CAM_File stand-in; miss addresses deliberately nonzero
  always_comb begin
    cam_valid = 1'b0;
    cam_min   = 3'd7;
    cam_max   = 3'd7;
    for (int i = 0; i < 8; i++) begin
      if (cam_mem[i] == cam_lookup) begin
        if (!cam_valid) cam_min = 3'(i);
        cam_max   = 3'(i);
        cam_valid = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (cam_init) cam_mem[i] <= TBL[i];
      else if (cam_setD && cam_mem[i] == cam_lookup) cam_mem[i] <= cam_newD;
    end
  end

  function automatic void ref_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = TBL[i];
    ref_cnt  = 0;
    ref_last = 1;
  endfunction

  function automatic void model(input logic [1:0] op, input logic [3:0] key,
                                input logic [3:0] nw, output logic hit,
                                output logic [2:0] mn, output logic [2:0] mx,
                                output int lat);
    hit = 1'b0; mn = 3'd0; mx = 3'd0; lat = 2;
    if (op == 2'b10) begin
      for (int i = 0; i < 8; i++) ref_mem[i] = TBL[i];
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (ref_mem[i] == key) begin
          if (!hit) mn = 3'(i);
          mx  = 3'(i);
          hit = 1'b1;
        end
      end
      if (op == 2'b01 && hit) begin
        lat = 3;
        for (int i = 0; i < 8; i++) if (ref_mem[i] == key) ref_mem[i] = nw;
      end
    end
    if (hit && ref_cnt < 255) ref_cnt++;
  endfunction

  // Entered in the accept cycle; follows the command to its response.
  task automatic run_cmd(input int id, input logic [1:0] op,
                         input logic [3:0] key, input logic [3:0] nw,
                         input bit hold, input string tag);
    logic hit;
    logic [2:0] mn, mx;
    int lat;
    int setd = 0;
    model(op, key, nw, hit, mn, mx, lat);
    ref_last = id;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (!hold) req_valid[id] = 1'b0;
      setd += int'(cam_setD);
      if (c < lat) begin
        n_chk++;
        if (rsp_valid !== 1'b0)
          $display("FAIL %s early_rsp c=%0d got=%b want=0", tag, c, rsp_valid);
        else n_pass++;
      end
    end
    n_chk++;
    if ({rsp_valid, rsp_id, rsp_hit, rsp_min, rsp_max} !== {1'b1, 1'(id), hit, mn, mx})
      $display("FAIL %s rsp got v%b id%b h%b mn%0d mx%0d want v1 id%0d h%b mn%0d mx%0d",
               tag, rsp_valid, rsp_id, rsp_hit, rsp_min, rsp_max, id, hit, mn, mx);
    else n_pass++;
    n_chk++;
    if (setd != ((op == 2'b01 && hit) ? 1 : 0))
      $display("FAIL %s setD_cycles got=%0d want=%0d", tag, setd,
               (op == 2'b01 && hit) ? 1 : 0);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (hit_cnt !== 8'(ref_cnt) || rsp_valid !== 1'b0)
      $display("FAIL %s hit_cnt got=%0d/v%b want=%0d/v0", tag, hit_cnt, rsp_valid, ref_cnt);
    else n_pass++;
  endtask

  task automatic send(input int id, input logic [1:0] op, input logic [3:0] key,
                      input logic [3:0] nw, input string tag);
    int n = 0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_key[id]   = key;
    req_new[id]   = nw;
    #1;
    while (req_ready[id] !== 1'b1 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    n_chk++;
    if (req_ready !== 2'(1 << id)) begin
      $display("FAIL %s grant got=%b want=%b", tag, req_ready, 2'(1 << id));
      req_valid[id] = 1'b0;
      @(negedge clk);
    end else begin
      n_pass++;
      run_cmd(id, op, key, nw, 1'b0, tag);
    end
  endtask

  task automatic test_reset();
    logic [29:0] got;
    init = 1'b1;
    req_valid = 2'b00; req_op = '0; req_key = '0; req_new = '0;
    repeat (3) @(negedge clk);
    got = {req_ready, rsp_valid, rsp_hit, rsp_min, rsp_max, rsp_id, hit_cnt,
           cam_setD, cam_lookup, cam_newD, cam_init, busy};
    n_chk++;
    if (got !== 30'b11) $display("FAIL reset_state got=%h want=%h", got, 30'b11);
    else n_pass++;
    init = 1'b0;
    ref_reset();
    #1;
    n_chk++;
    if (cam_init !== 1'b1) $display("FAIL release_init got=%b want=1", cam_init);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({cam_init, busy, req_ready, rsp_valid} !== 5'b0)
      $display("FAIL idle_after_release got=%b want=00000",
               {cam_init, busy, req_ready, rsp_valid});
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (cam_init !== 1'b0 || busy !== 1'b0)
      $display("FAIL init_one_cycle got=%b%b want=00", cam_init, busy);
    else n_pass++;
  endtask

  task automatic test_lookup();
    send(0, 2'b00, 4'hB, 4'h0, "lookup_1011");
    send(1, 2'b11, 4'hB, 4'h0, "lookup_op11");
    send(1, 2'b00, 4'h5, 4'h0, "lookup_miss");
  endtask

  task automatic test_replace();
    send(1, 2'b01, 4'hB, 4'hE, "replace_hit");
    send(0, 2'b00, 4'hB, 4'h0, "after_repl_old");
    send(1, 2'b00, 4'hE, 4'h0, "after_repl_new");
    send(0, 2'b01, 4'h6, 4'hA, "replace_miss");
    send(0, 2'b00, 4'hA, 4'h0, "miss_unchanged");
  endtask

  task automatic test_clear();
    send(1, 2'b10, 4'h0, 4'h0, "clear");
    send(0, 2'b00, 4'hB, 4'h0, "after_clear");
    send(0, 2'b01, 4'h3, 4'h3, "key_eq_new");
    send(1, 2'b00, 4'h3, 4'h0, "key_eq_new_look");
  endtask

  task automatic test_back_to_back(input int first);
    logic [3:0] keys [2];
    int n;
    int exp;
    send(1 - first, 2'b00, 4'h1, 4'h0, "b2b_prime");
    for (int r = 0; r < 2; r++) begin
      keys[r]    = (r == 0) ? 4'hB : 4'(r + $urandom_range(0, 7));
      req_op[r]  = 2'b00;
      req_key[r] = keys[r];
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (req_ready === 2'b00 && n < 10) begin
        @(negedge clk); #1; n++;
      end
      exp = (ref_last == 0) ? 1 : 0;
      n_chk++;
      if (req_ready !== 2'(1 << exp)) begin
        $display("FAIL b2b_grant k=%0d got=%b want=%b", k, req_ready, 2'(1 << exp));
        break;
      end
      n_pass++;
      run_cmd(exp, 2'b00, keys[exp], 4'h0, 1'b1, "b2b");
    end
    req_valid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_random();
    int id;
    logic [1:0] op;
    logic [3:0] key;
    for (int t = 0; t < 40; t++) begin
      id  = $urandom_range(0, 1);
      op  = 2'($urandom_range(0, 3));
      key = ($urandom_range(0, 1) == 1) ? TBL[$urandom_range(0, 7)] : 4'($urandom);
      send(id, op, key, 4'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_wr();
    int n = 0;
    send(0, 2'b10, 4'h0, 4'h0, "pre_clear");
    req_valid[1] = 1'b1; req_op[1] = 2'b01;
    req_key[1] = 4'hB; req_new[1] = 4'hE;
    #1;
    while (cam_setD !== 1'b1 && n < 6) begin
      @(negedge clk); #1; n++;
      req_valid[1] = 1'b0;
    end
    n_chk++;
    if (cam_setD !== 1'b1) $display("FAIL midwr_reach got=%b want=1", cam_setD);
    else n_pass++;
    init = 1'b1;
    #1;
    n_chk++;
    if ({cam_setD, cam_init, rsp_valid, busy} !== 4'b0101)
      $display("FAIL midwr_abort got=%b want=0101", {cam_setD, cam_init, rsp_valid, busy});
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_chk++;
      if (rsp_valid !== 1'b0) $display("FAIL midwr_norsp got=%b want=0", rsp_valid);
      else n_pass++;
    end
    init = 1'b0;
    ref_reset();
    #1;
    n_chk++;
    if (cam_init !== 1'b1) $display("FAIL midwr_clr got=%b want=1", cam_init);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({cam_init, busy, rsp_valid} !== 3'b0 || hit_cnt !== 8'd0)
      $display("FAIL midwr_idle got=%b cnt=%0d want=000 cnt=0",
               {cam_init, busy, rsp_valid}, hit_cnt);
    else n_pass++;
    send(0, 2'b00, 4'hB, 4'h0, "midwr_unwritten");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    init = 1'b1;
    @(negedge clk);
    test_reset();
    test_lookup();
    test_replace();
    test_clear();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
